wifi_rx_demapper_16qam: RTL and testbench

Receive-side 16-QAM demapper for the WIFI PHY: it takes equalised 12-bit signed I/Q samples and produces the 4-bit hard-decision symbol plus 4 saturated soft bits (LLRs) per symbol. It is the inverse of the TX 16-QAM mapper and uses the same Gray map and levels ±162/±486. A 2-stage pipeline feeds a small first-word-fall-through (FWFT) output FIFO with valid/ready backpressure toward the deinterleaver.

---
 rtl/wifi_rx_demapper_16qam.sv | 90 +++++++++
 tb/tb_wifi_rx_demapper_16qam.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wifi_rx_demapper_16qam.sv
// wifi_rx_demapper_16qam: 16-QAM hard/soft demapper, 2-stage pipeline into an FWFT output FIFO.
module wifi_rx_demapper_16qam #(
    parameter int THRESH     = 324,
    parameter int FIFO_DEPTH = 4,
    parameter int LLR_W      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic [11:0]          data_in_real,
    input  logic [11:0]          data_in_imag,
    output logic                 in_ready,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic [3:0]           data_out,
    output logic [4*LLR_W-1:0]   llr_out,
    output logic                 overflow,
    output logic [15:0]          sym_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [13:0] SAT_HI = 14'(2**(LLR_W-1)-1);
    localparam logic signed [13:0] SAT_LO = ~SAT_HI;
    localparam logic signed [13:0] TH = 14'(THRESH);

    logic                     s1_valid;
    logic signed [12:0]       s1_re, s1_im, in_re, in_im;
    logic [12:0]              s1_are, s1_aim, in_are, in_aim;
    logic [AW:0]              count;
    logic [AW-1:0]            wptr, rptr;
    logic [3:0]               mem_d [FIFO_DEPTH];
    logic [4*LLR_W-1:0]       mem_l [FIFO_DEPTH];
    logic                     accept, rd;
    logic signed [13:0]       xr, xi, dr, di;
    logic [3:0]               wr_d;
    logic [4*LLR_W-1:0]       wr_l;

    function automatic logic signed [LLR_W-1:0] sat(input logic signed [13:0] v);
        return v > SAT_HI ? SAT_HI[LLR_W-1:0] : v < SAT_LO ? SAT_LO[LLR_W-1:0] : v[LLR_W-1:0];
    endfunction

    // Reserving a slot for the sample already in stage 1 keeps ready_out off this path.
    assign in_ready  = ~reset & (({1'b0, count} + (AW+2)'(s1_valid)) < (AW+2)'(FIFO_DEPTH));
    assign accept    = valid_in & in_ready;
    assign valid_out = count != 0;
    assign rd        = valid_out & ready_out;
    assign data_out  = valid_out ? mem_d[rptr] : '0;
    assign llr_out   = valid_out ? mem_l[rptr] : '0;

    assign in_re  = 13'($signed(data_in_real));
    assign in_im  = 13'($signed(data_in_imag));
    assign in_are = in_re[12] ? 13'(-in_re) : in_re;
    assign in_aim = in_im[12] ? 13'(-in_im) : in_im;

    assign xr   = 14'(s1_re);
    assign xi   = 14'(s1_im);
    assign dr   = TH - $signed({1'b0, s1_are});
    assign di   = TH - $signed({1'b0, s1_aim});
    assign wr_d = {~s1_re[12], s1_are < 13'(THRESH), ~s1_im[12], s1_aim < 13'(THRESH)};
    assign wr_l = {sat(xr >>> 5), sat(dr >>> 5), sat(xi >>> 5), sat(di >>> 5)};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            count     <= '0;
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            sym_count <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_re  <= in_re;
                s1_im  <= in_im;
                s1_are <= in_are;
                s1_aim <= in_aim;
            end
            if (valid_in & ~in_ready) overflow <= 1'b1;
            if (s1_valid) begin
                mem_d[wptr] <= wr_d;
                mem_l[wptr] <= wr_l;
                wptr        <= wptr + 1'b1;
            end
            if (rd) begin
                rptr      <= rptr + 1'b1;
                sym_count <= sym_count + 16'd1;
            end
            count <= count + (AW+1)'(s1_valid) - (AW+1)'(rd);
        end
    end
endmodule

// File: tb/tb_wifi_rx_demapper_16qam.sv
// tb_wifi_rx_demapper_16qam: directed bench with an expected-result queue for the 16-QAM demapper.
module tb_wifi_rx_demapper_16qam;
    localparam int TH = 324;

    typedef struct {
        logic [3:0]  d;
        logic [19:0] l;
        int          acc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset, valid_in, ready_out;
    logic [11:0] data_in_real, data_in_imag;
    logic        in_ready, valid_out, overflow;
    logic [3:0]  data_out;
    logic [19:0] llr_out;
    logic [15:0] sym_count;

    int   tests = 0, fails = 0, cyc = 0;
    bit   lat_chk = 0;
    ent_t sb[$];

    wifi_rx_demapper_16qam dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .data_in_real(data_in_real), .data_in_imag(data_in_imag),
        .in_ready(in_ready), .valid_out(valid_out), .ready_out(ready_out),
        .data_out(data_out), .llr_out(llr_out), .overflow(overflow), .sym_count(sym_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", n, o, e);
        end
    endtask

    function automatic int ab(input int v);
        return v < 0 ? -v : v;
    endfunction

    function automatic int fl32(input int v);
        return v >= 0 ? v / 32 : -((-v + 31) / 32);
    endfunction

    function automatic int sat(input int v);
        return v > 15 ? 15 : v < -16 ? -16 : v;
    endfunction

    function automatic ent_t model(input int r, input int i);
        ent_t e;
        e.d = {r >= 0, ab(r) < TH, i >= 0, ab(i) < TH};
        e.l = {5'(sat(fl32(r))), 5'(sat(fl32(TH - ab(r)))), 5'(sat(fl32(i))), 5'(sat(fl32(TH - ab(i))))};
        e.acc = 0;
        return e;
    endfunction

    // Scoreboard: push on every accepted sample, pop on every downstream read.
    always @(negedge clk) begin
        ent_t e;
        if (!reset && valid_out && ready_out) begin
            if (sb.size() == 0) chk("sb_underrun", 32'(valid_out), 32'(0));
            else begin
                e = sb.pop_front();
                chk("data", 32'(data_out), 32'(e.d));
                chk("llr", 32'(llr_out), 32'(e.l));
                if (lat_chk) chk("latency", 32'(cyc), 32'(e.acc + 1));
            end
        end
        if (valid_in && in_ready) begin
            e = model(int'($signed(data_in_real)), int'($signed(data_in_imag)));
            e.acc = cyc + 1;
            sb.push_back(e);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input int i);
        int t = 0;
        while (!in_ready && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) chk("send_timeout", 32'(in_ready), 32'(1));
        valid_in = 1'b1;
        data_in_real = 12'(r);
        data_in_imag = 12'(i);
        step();
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        ready_out = 1'b1;
        while ((sb.size() != 0 || valid_out) && t < 1000) begin
            step();
            t++;
        end
        chk("drain_done", 32'(t < 1000), 32'(1));
    endtask

    initial begin
        int lv[4] = '{-486, -162, 162, 486};
        int br[7] = '{486, -486, 0, 324, -324, -2048, 2047};
        int eb[7] = '{2, 0, 3, 2, 0, 0, 2};
        int e3[7] = '{15, -16, 0, 10, -11, -16, 15};
        int e2[7] = '{-6, -6, 10, 0, 0, -16, -16};
        logic [3:0]  hd;
        logic [19:0] hl;
        reset = 1'b1; valid_in = 1'b0; ready_out = 1'b0;
        data_in_real = '0; data_in_imag = '0;
        step(); step();
        chk("rst_valid_out", 32'(valid_out), 32'(0));
        chk("rst_data_out", 32'(data_out), 32'(0));
        chk("rst_llr_out", 32'(llr_out), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        chk("rst_sym_count", 32'(sym_count), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        reset = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'(1));

        // Constellation sweep, back-to-back with latency checking.
        ready_out = 1'b1;
        lat_chk = 1;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) send(lv[a], lv[b]);
        drain();
        lat_chk = 0;
        chk("sweep_count", 32'(sym_count), 32'(16));

        // LLR and decision boundaries, observed at the FIFO head.
        for (int k = 0; k < 7; k++) begin
            ready_out = 1'b0;
            send(br[k], 162);
            step();
            chk("bnd_valid", 32'(valid_out), 32'(1));
            chk("bnd_b3b2", 32'(data_out[3:2]), 32'(eb[k]));
            chk("bnd_llr3", 32'($signed(llr_out[19:15])), 32'(e3[k]));
            chk("bnd_llr2", 32'($signed(llr_out[14:10])), 32'(e2[k]));
            drain();
        end

        // Backpressure: four fill the pipe, then the head must stay put.
        ready_out = 1'b0;
        send(162, -486); send(-486, 486); send(486, 162); send(-162, -162);
        chk("bp_in_ready_low", 32'(in_ready), 32'(0));
        chk("bp_held", 32'(sb.size()), 32'(4));
        step();
        chk("bp_in_ready_still_low", 32'(in_ready), 32'(0));
        chk("bp_head_valid", 32'(valid_out), 32'(1));
        chk("bp_head_data", 32'(data_out), 32'(4'b1100));
        hd = data_out; hl = llr_out;
        step(); step(); step();
        chk("bp_head_stable_d", 32'(data_out), 32'(hd));
        chk("bp_head_stable_l", 32'(llr_out), 32'(hl));
        ready_out = 1'b1;
        send(486, -486); send(-162, 486);
        drain();
        chk("bp_no_overflow", 32'(overflow), 32'(0));

        // Overflow: one illegal sample against a full FIFO.
        ready_out = 1'b0;
        send(-486, -486); send(162, 162); send(486, 486); send(-162, 162);
        step(); step();
        hd = data_out; hl = llr_out;
        valid_in = 1'b1; data_in_real = 12'(486); data_in_imag = 12'(-162);
        step();
        valid_in = 1'b0;
        chk("ovf_set", 32'(overflow), 32'(1));
        step(); step(); step();
        chk("ovf_sticky", 32'(overflow), 32'(1));
        chk("ovf_head_d", 32'(data_out), 32'(hd));
        chk("ovf_head_l", 32'(llr_out), 32'(hl));
        chk("ovf_queue", 32'(sb.size()), 32'(4));
        drain();
        chk("ovf_still_set", 32'(overflow), 32'(1));

        // Reset with three queued entries and stage 1 occupied.
        ready_out = 1'b0;
        send(486, 162); send(-486, 162); send(162, 486); send(-162, -486);
        reset = 1'b1;
        sb.delete();
        step();
        chk("mrst_valid_out", 32'(valid_out), 32'(0));
        chk("mrst_sym_count", 32'(sym_count), 32'(0));
        chk("mrst_overflow", 32'(overflow), 32'(0));
        chk("mrst_in_ready", 32'(in_ready), 32'(0));
        reset = 1'b0;
        #1;
        chk("mrst_in_ready_rel", 32'(in_ready), 32'(1));
        ready_out = 1'b1;
        lat_chk = 1;
        send(162, -486);
        drain();
        lat_chk = 0;
        chk("mrst_one_out", 32'(sym_count), 32'(1));

        // Counter wrap over 65537 reads with random samples.
        reset = 1'b1;
        step();
        reset = 1'b0;
        ready_out = 1'b1;
        for (int n = 0; n < 65537; n++)
            send(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048);
        drain();
        chk("wrap_sym_count", 32'(sym_count), 32'(1));
        chk("wrap_overflow", 32'(overflow), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
